// File: rtl/e3_s3.sv
// ---------------------------------------------------------------------------
// e3_s3 : bank of WIDTH independent rising-edge JK flip-flops with
//         complementary outputs and an asynchronous active-low clear.
//
// Parameters
//   WIDTH       : number of independent JK cells (>= 1)
//   RESET_VALUE : value forced onto q while reset is low (qb gets ~RESET_VALUE)
//
// Ports
//   clk   in  1      rising-edge clock shared by all cells
//   reset in  1      asynchronous, active-low clear (0 = in reset)
//   j     in  WIDTH  per-cell J (set) input
//   k     in  WIDTH  per-cell K (clear) input
//   q     out WIDTH  registered state
//   qb    out WIDTH  bitwise complement of q
// ---------------------------------------------------------------------------
module e3_s3 #(
  parameter int                 WIDTH       = 1,
  parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb
);

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] q_next;

  // Each cell follows the JK characteristic equation: a set term that only
  // fires while the cell is 0, and a hold term that survives unless K is high.
  // With j=k=1 this reduces to a toggle.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_cell
      assign q_next[gi] = (j[gi] & ~q_reg[gi]) | (~k[gi] & q_reg[gi]);
    end
  endgenerate

  // Reset is on the sensitivity list so it clears the bank without a clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_reg <= RESET_VALUE;
    end else begin
      q_reg <= q_next;
    end
  end

  assign q  = q_reg;
  // Derived from the same register so qb tracks q through reset as well.
  assign qb = ~q_reg;

endmodule

// File: tb/tb_e3_s3.sv
module tb_e3_s3;

  logic       clk = 1'b1;
  logic       reset;
  logic       j, k;
  logic       q, qb;

  logic       reset4;
  logic [3:0] j4, k4;
  logic [3:0] q4, qb4;

  int vectors     = 0;
  int miscompares = 0;

  localparam logic [3:0] RV4 = 4'b1010;

  e3_s3 #(.WIDTH(1)) dut (
    .clk  (clk),
    .reset(reset),
    .j    (j),
    .k    (k),
    .q    (q),
    .qb   (qb)
  );

  e3_s3 #(.WIDTH(4), .RESET_VALUE(RV4)) dut4 (
    .clk  (clk),
    .reset(reset4),
    .j    (j4),
    .k    (k4),
    .q    (q4),
    .qb   (qb4)
  );

  always #5 clk = ~clk;

  // Behavioural reference: plain JK truth table for one cell.
  function automatic logic jk_model(input logic cur, input logic jj, input logic kk);
    if (jj && kk)      return !cur;
    else if (jj)       return 1'b1;
    else if (kk)       return 1'b0;
    else               return cur;
  endfunction

  function automatic logic [3:0] jk_model4(input logic [3:0] cur, input logic [3:0] jj,
                                           input logic [3:0] kk);
    logic [3:0] r;
    for (int b = 0; b < 4; b++) r[b] = jk_model(cur[b], jj[b], kk[b]);
    return r;
  endfunction

  // Reset held low while j/k wiggle across several edges.
  task automatic test_reset();
    logic [1:0] jk_seq [6];
    jk_seq[0] = 2'b10; jk_seq[1] = 2'b00; jk_seq[2] = 2'b01;
    jk_seq[3] = 2'b00; jk_seq[4] = 2'b11; jk_seq[5] = 2'b11;
    reset  = 1'b0;
    reset4 = 1'b0;
    j4 = 4'b0000; k4 = 4'b0000;
    for (int s = 0; s < 6; s++) begin
      j = jk_seq[s][1];
      k = jk_seq[s][0];
      #2;
      vectors++;
      if (q !== 1'b0 || qb !== 1'b1) begin
        miscompares++;
        $display("FAIL reset_hold step %0d: q=%b qb=%b, want q=0 qb=1", s, q, qb);
      end else
        $display("reset_hold step %0d: j=%b k=%b q=%b qb=%b", s, j, k, q, qb);
      #3;
    end
  endtask

  task automatic test_async_mid();
    @(negedge clk);
    reset = 1'b1; j = 1'b1; k = 1'b0;
    @(negedge clk);
    vectors++;
    if (q !== 1'b1 || qb !== 1'b0) begin
      miscompares++;
      $display("FAIL async_pre set: q=%b qb=%b, want q=1 qb=0", q, qb);
    end else
      $display("async_pre set: q=%b qb=%b", q, qb);
    #2;
    reset = 1'b0;
    #1;
    vectors++;
    if (q !== 1'b0 || qb !== 1'b1) begin
      miscompares++;
      $display("FAIL async_mid clear: q=%b qb=%b, want q=0 qb=1", q, qb);
    end else
      $display("async_mid clear: q=%b qb=%b", q, qb);
  endtask

  task automatic test_truth_table();
    logic [1:0] tt [5];
    logic       exp_q;
    tt[0] = 2'b10; tt[1] = 2'b00; tt[2] = 2'b01; tt[3] = 2'b11; tt[4] = 2'b11;
    @(negedge clk);
    reset = 1'b1;
    exp_q = 1'b0;
    for (int s = 0; s < 5; s++) begin
      j = tt[s][1];
      k = tt[s][0];
      exp_q = jk_model(exp_q, j, k);
      @(negedge clk);
      vectors++;
      if (q !== exp_q || qb !== ~exp_q) begin
        miscompares++;
        $display("FAIL truth_table row %0d j=%b k=%b: q=%b qb=%b, want q=%b qb=%b",
                 s, j, k, q, qb, exp_q, ~exp_q);
      end else
        $display("truth_table row %0d: j=%b k=%b q=%b qb=%b", s, j, k, q, qb);
    end
  endtask

  task automatic test_toggle();
    logic exp_q;
    @(negedge clk);
    reset = 1'b0;
    #1;
    reset = 1'b1;
    j = 1'b1; k = 1'b1;
    exp_q = 1'b0;
    for (int e = 0; e < 8; e++) begin
      @(posedge clk);
      #1;
      exp_q = (e % 2 == 0) ? 1'b1 : 1'b0;
      vectors++;
      if (q !== exp_q || qb !== ~exp_q) begin
        miscompares++;
        $display("FAIL toggle edge %0d: q=%b qb=%b, want q=%b", e, q, qb, exp_q);
      end else
        $display("toggle edge %0d: q=%b qb=%b", e, q, qb);
      @(negedge clk);
      #1;
      vectors++;
      if (q !== exp_q) begin
        miscompares++;
        $display("FAIL toggle falling %0d: q=%b, want q=%b", e, q, exp_q);
      end
    end
  endtask

  task automatic test_coincident_release();
    @(negedge clk);
    reset = 1'b0;
    j = 1'b1; k = 1'b0;
    @(posedge clk);
    // Non-blocking so the release lands after the flop has already
    // evaluated this edge, i.e. the edge still sees reset asserted.
    reset <= 1'b1;
    #1;
    vectors++;
    if (q !== 1'b0 || qb !== 1'b1) begin
      miscompares++;
      $display("FAIL coincident_edge: q=%b qb=%b, want q=0 qb=1", q, qb);
    end else
      $display("coincident_edge: q=%b qb=%b", q, qb);
    @(posedge clk);
    #1;
    vectors++;
    if (q !== 1'b1 || qb !== 1'b0) begin
      miscompares++;
      $display("FAIL coincident_next: q=%b qb=%b, want q=1 qb=0", q, qb);
    end else
      $display("coincident_next: q=%b qb=%b", q, qb);
  endtask

  task automatic test_width4();
    @(negedge clk);
    reset4 = 1'b0;
    #1;
    vectors++;
    if (q4 !== RV4 || qb4 !== ~RV4) begin
      miscompares++;
      $display("FAIL w4_reset: q=%b qb=%b, want q=%b qb=%b", q4, qb4, RV4, ~RV4);
    end else
      $display("w4_reset: q=%b qb=%b", q4, qb4);
    reset4 = 1'b1;
    j4 = 4'b0011; k4 = 4'b0101;
    @(negedge clk);
    vectors++;
    if (q4 !== 4'b1011 || qb4 !== 4'b0100) begin
      miscompares++;
      $display("FAIL w4_mixed: q=%b qb=%b, want q=1011 qb=0100", q4, qb4);
    end else
      $display("w4_mixed: j=%b k=%b q=%b qb=%b", j4, k4, q4, qb4);
  endtask

  task automatic test_random();
    logic [3:0] m4;
    logic       m1;
    @(negedge clk);
    reset = 1'b0; reset4 = 1'b0;
    #1;
    reset = 1'b1; reset4 = 1'b1;
    m4 = RV4;
    m1 = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(15) == 0) begin
        reset4 = 1'b0;
        reset  = 1'b0;
        #1;
        m4 = RV4;
        m1 = 1'b0;
        vectors++;
        if (q4 !== RV4 || q !== 1'b0) begin
          miscompares++;
          $display("FAIL rand_reset %0d: q4=%b q=%b, want q4=%b q=0", n, q4, q, RV4);
        end
        #1;
        reset4 = 1'b1;
        reset  = 1'b1;
      end
      j4 = 4'($urandom);
      k4 = 4'($urandom);
      j  = 1'($urandom);
      k  = 1'($urandom);
      @(posedge clk);
      #1;
      m4 = jk_model4(m4, j4, k4);
      m1 = jk_model(m1, j, k);
      vectors++;
      if (q4 !== m4 || qb4 !== ~m4 || q !== m1 || qb !== ~m1) begin
        miscompares++;
        $display("FAIL rand %0d: j4=%b k4=%b q4=%b qb4=%b q=%b qb=%b, want q4=%b q=%b",
                 n, j4, k4, q4, qb4, q, qb, m4, m1);
      end else
        $display("rand %0d: j4=%b k4=%b q4=%b j=%b k=%b q=%b", n, j4, k4, q4, j, k, q);
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_async_mid();
    test_truth_table();
    test_toggle();
    test_coincident_release();
    test_width4();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
